// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block/round constants, sequencer state encoding
// and FIPS-197 reference vectors used by the bench.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES_NR    = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } aes_fsm_e;

  // FIPS-197 Appendix B
  localparam logic [AES_BLK_W-1:0] FIPS_B_KEY      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [AES_BLK_W-1:0] FIPS_B_PT       = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [AES_BLK_W-1:0] FIPS_B_CT       = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [AES_BLK_W-1:0] FIPS_B_R0_STATE = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [AES_BLK_W-1:0] FIPS_B_K1       = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [AES_BLK_W-1:0] FIPS_B_K10      = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  // FIPS-197 Appendix C.1
  localparam logic [AES_BLK_W-1:0] FIPS_C1_KEY     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [AES_BLK_W-1:0] FIPS_C1_PT      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [AES_BLK_W-1:0] FIPS_C1_CT      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer: accepts a plaintext/key pair, steps an external
// single-round datapath through rounds 0..NUM_ROUNDS, then offers the ciphertext.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NR,
  parameter int unsigned RND_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  input  logic [AES_BLK_W-1:0] in_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 busy,
  output logic [RND_W-1:0]     rnd_idx,
  output logic [AES_BLK_W-1:0] rnd_state,
  output logic [AES_BLK_W-1:0] rnd_key,
  input  logic [AES_BLK_W-1:0] rnd_state_in,
  input  logic [AES_BLK_W-1:0] rnd_key_in
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  aes_fsm_e             fsm;
  logic [AES_BLK_W-1:0] state_q;
  logic [AES_BLK_W-1:0] key_q;
  logic [3:0]           rnd_q;

  assign rnd_state = state_q;
  assign rnd_key   = key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state_q   <= '0;
      key_q     <= '0;
      rnd_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      rnd_idx   <= '0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_q  <= in_data;
            key_q    <= in_key;
            rnd_q    <= '0;
            rnd_idx  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            fsm      <= RUN;
          end
        end
        RUN: begin
          state_q <= rnd_state_in;
          // Round 0 is the plain key whitening, so K0 stays the cipher key.
          if (rnd_q != '0) key_q <= rnd_key_in;
          if (rnd_q == LAST_RND) begin
            out_valid <= 1'b1;
            out_data  <= rnd_state_in;
            rnd_idx   <= '0;
            fsm       <= DONE;
          end else begin
            rnd_q   <= rnd_q + 4'd1;
            rnd_idx <= RND_W'(rnd_q + 4'd1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES round datapath plus an independent
// whole-block AES-128 reference, table-driven vectors and corner sequences.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;
  logic [4:0]   rnd_idx;
  logic [127:0] rnd_state, rnd_key, rnd_state_in, rnd_key_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_ctrl #(.NUM_ROUNDS(AES_NR), .RND_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .rnd_idx(rnd_idx), .rnd_state(rnd_state), .rnd_key(rnd_key),
    .rnd_state_in(rnd_state_in), .rnd_key_in(rnd_key_in)
  );

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = gmul(rc, 8'h02);
    return rc;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int r, c, src;
    for (int i = 0; i < 16; i++) begin
      r   = i % 4;
      c   = i / 4;
      src = r + 4 * ((c + r) % 4);
      o[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input int r);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(r), 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Whole-block reference: full word-array key schedule, then all rounds.
  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [127:0] s;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / 4), 24'h0};
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      s = sub_shift(s);
      if (r < 10) s = mix_cols(s);
      s ^= {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  // Behavioural round datapath driven by the controller.
  function automatic logic [127:0] dp_key(input logic [4:0] idx, input logic [127:0] k);
    if (idx >= 5'd1 && idx <= 5'd10) return next_key(k, int'(idx));
    return k;
  endfunction

  function automatic logic [127:0] dp_state(input logic [4:0] idx, input logic [127:0] s,
                                            input logic [127:0] k);
    logic [127:0] o;
    if (idx == 5'd0 || idx > 5'd10) return s ^ k;
    o = sub_shift(s);
    if (idx != 5'd10) o = mix_cols(o);
    return o ^ next_key(k, int'(idx));
  endfunction

  assign rnd_key_in   = dp_key(rnd_idx, rnd_key);
  assign rnd_state_in = dp_state(rnd_idx, rnd_state, rnd_key);

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_rnd_idx"}, rnd_idx, 0);
    chk({tag, "_rnd_state"}, rnd_state, 0);
    chk({tag, "_rnd_key"}, rnd_key, 0);
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] p, output int t_acc);
    int n = 0;
    in_valid = 1'b1;
    in_key   = k;
    in_data  = p;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_in_ready", in_ready, 1);
    @(posedge clk); #1;
    t_acc    = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int t_acc, output logic [127:0] ct, output int lat);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_seen", out_valid, 1);
    lat = cyc - t_acc;
    ct  = out_data;
  endtask

  task automatic handshake(input int stall, input logic [127:0] exp_ct);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, exp_ct);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    chk("hs_busy", busy, 0);
  endtask

  task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                           input logic [127:0] exp_ct, input int stall);
    int t, lat;
    logic [127:0] ct;
    send(k, p, t);
    wait_out(t, ct, lat);
    chk("blk_ct", ct, exp_ct);
    chk("blk_latency", lat, 11);
    handshake(stall, exp_ct);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, tv, lat, n;
    logic acc, got;
    logic [127:0] ct, ct1;

    vecs[0] = '{FIPS_B_KEY, FIPS_B_PT, FIPS_B_CT};
    vecs[1] = '{FIPS_C1_KEY, FIPS_C1_PT, FIPS_C1_CT};
    for (int i = 2; i < 8; i++) begin
      vecs[i].key = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].ct  = aes_ref(vecs[i].key, vecs[i].pt);
    end

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // App. B with per-round probes
    send(FIPS_B_KEY, FIPS_B_PT, t0);
    for (int k = 0; k <= 10; k++) begin
      chk("probe_rnd_idx", rnd_idx, k);
      chk("probe_busy", busy, 1);
      chk("probe_in_ready", in_ready, 0);
      chk("probe_out_valid", out_valid, 0);
      if (k == 1) chk("probe_state_r0", rnd_state, FIPS_B_R0_STATE);
      if (k == 2) chk("probe_key_r1", rnd_key, FIPS_B_K1);
      @(posedge clk); #1;
    end
    chk("probe_done_valid", out_valid, 1);
    chk("probe_done_ct", out_data, FIPS_B_CT);
    chk("probe_done_latency", cyc - t0, 11);
    chk("probe_key_r10", rnd_key, FIPS_B_K10);
    chk("probe_done_rnd_idx", rnd_idx, 0);
    handshake(0, FIPS_B_CT);

    // Back-to-back B then C.1, out_ready held high throughout
    out_ready = 1'b1;
    send(FIPS_B_KEY, FIPS_B_PT, t1);
    in_valid = 1'b1;
    in_key   = FIPS_C1_KEY;
    in_data  = FIPS_C1_PT;
    got = 1'b0;
    t2  = -1000;
    tv  = -1000;
    ct1 = 'x;
    for (int i = 0; i < 40 && t2 < 0; i++) begin
      if (out_valid && !got) begin
        got = 1'b1;
        ct1 = out_data;
        tv  = cyc;
      end
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        t2       = cyc;
        in_valid = 1'b0;
      end
    end
    chk("b2b_first_ct", ct1, FIPS_B_CT);
    chk("b2b_first_latency", tv - t1, 11);
    // accept cycle, rounds 0..10, DONE handshake cycle, then the next IDLE accept
    chk("b2b_accept_gap", t2 - t1, 1 + (AES_NR + 1) + 1);
    wait_out(t2, ct, lat);
    chk("b2b_second_ct", ct, FIPS_C1_CT);
    chk("b2b_second_latency", lat, 11);
    @(posedge clk); #1;
    chk("b2b_second_taken", out_valid, 0);
    out_ready = 1'b0;

    // Backpressure with ignored in_valid
    send(FIPS_C1_KEY, FIPS_C1_PT, t0);
    wait_out(t0, ct, lat);
    chk("bp_ct", ct, FIPS_C1_CT);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, FIPS_C1_CT);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    handshake(0, FIPS_C1_CT);
    @(posedge clk); #1;
    chk("bp_idle_busy", busy, 0);

    // Asynchronous reset in the middle of round 5
    send(FIPS_B_KEY, FIPS_B_PT, t0);
    n = 0;
    while (rnd_idx != 5'd5 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_reached_r5", rnd_idx, 5);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    @(posedge clk); #1;
    chk_reset("mid_rst_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_block(FIPS_B_KEY, FIPS_B_PT, FIPS_B_CT, 0);

    // Garbage in_valid toggling while running
    send(FIPS_B_KEY, FIPS_B_PT, t0);
    n = 0;
    while (!out_valid && n < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("garbage_out_valid", out_valid, 1);
    chk("garbage_ct", out_data, FIPS_B_CT);
    chk("garbage_latency", cyc - t0, 11);
    handshake(2, FIPS_B_CT);

    // Table-driven vectors with random output stalls
    for (int i = 0; i < 8; i++) begin
      run_block(vecs[i].key, vecs[i].pt, vecs[i].ct, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
